// File: rtl/rs5_machine_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp) and software interrupt (msip)
// responder for the RS5 data-memory bus; drives the core's MTI and MSI request lines.
module rs5_machine_timer #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic [3:0]  write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        mti_o,
    output logic        msi_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescaler_reg;
    logic          tick;
    logic [63:0]   mtime_reg, mtime_next;
    logic [63:0]   mtimecmp_reg, mtimecmp_next;
    logic          msip_reg, msip_next;
    logic [31:0]   rdata;
    logic          hit, wr;
    logic [9:0]    word;
    logic          sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic [31:0]   wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;

    // With TICK_DIV = 1 the prescaler never leaves 0, so tick is constantly 1.
    assign tick = (prescaler_reg == PW'(TICK_DIV - 1));

    assign hit         = enable_i && (addr_i[31:12] == BASE_ADDR[31:12]);
    assign wr          = hit && (write_enable_i != 4'b0000);
    assign word        = addr_i[11:2];
    assign sel_msip    = (word == 10'h000);
    assign sel_cmp_lo  = (word == 10'h002);
    assign sel_cmp_hi  = (word == 10'h003);
    assign sel_time_lo = (word == 10'h004);
    assign sel_time_hi = (word == 10'h005);

    // Byte-lane merge of write data over the current register contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_cmp_lo[gi*8 +: 8]  = write_enable_i[gi] ? data_i[gi*8 +: 8] : mtimecmp_reg[gi*8 +: 8];
            assign wr_cmp_hi[gi*8 +: 8]  = write_enable_i[gi] ? data_i[gi*8 +: 8] : mtimecmp_reg[32 + gi*8 +: 8];
            assign wr_time_lo[gi*8 +: 8] = write_enable_i[gi] ? data_i[gi*8 +: 8] : mtime_reg[gi*8 +: 8];
            assign wr_time_hi[gi*8 +: 8] = write_enable_i[gi] ? data_i[gi*8 +: 8] : mtime_reg[32 + gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        msip_next     = msip_reg;
        // A software write to either mtime word swallows that cycle's increment.
        if (wr && sel_time_lo) begin
            mtime_next[31:0] = wr_time_lo;
        end else if (wr && sel_time_hi) begin
            mtime_next[63:32] = wr_time_hi;
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
        if (wr && sel_cmp_lo) mtimecmp_next[31:0]  = wr_cmp_lo;
        if (wr && sel_cmp_hi) mtimecmp_next[63:32] = wr_cmp_hi;
        if (wr && sel_msip && write_enable_i[0]) msip_next = data_i[0];
    end

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            if (sel_msip)    rdata = {31'h0, msip_reg};
            if (sel_cmp_lo)  rdata = mtimecmp_reg[31:0];
            if (sel_cmp_hi)  rdata = mtimecmp_reg[63:32];
            if (sel_time_lo) rdata = mtime_reg[31:0];
            if (sel_time_hi) rdata = mtime_reg[63:32];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_reg <= '0;
            mtime_reg     <= 64'h0;
            mtimecmp_reg  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_reg      <= 1'b0;
            data_o        <= 32'h0;
            mti_o         <= 1'b0;
        end else begin
            prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
            mtime_reg     <= mtime_next;
            mtimecmp_reg  <= mtimecmp_next;
            msip_reg      <= msip_next;
            mti_o         <= (mtime_reg >= mtimecmp_reg);
            if (enable_i) data_o <= rdata;
        end
    end

    assign msi_o = msip_reg;

endmodule

// File: tb/tb_rs5_machine_timer.sv
// Directed, table-driven bench for rs5_machine_timer: one instance with TICK_DIV=1
// and one with TICK_DIV=4 share the same bus stimulus.
module tb_rs5_machine_timer;

    localparam logic [31:0] B = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rd1, rd4;
    logic        mti1, mti4, msi1, msi4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs5_machine_timer #(.TICK_DIV(1), .BASE_ADDR(B)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable), .write_enable_i(we),
        .addr_i(addr), .data_i(wdata), .data_o(rd1), .mti_o(mti1), .msi_o(msi1)
    );

    rs5_machine_timer #(.TICK_DIV(4), .BASE_ADDR(B)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable_i(enable), .write_enable_i(we),
        .addr_i(addr), .data_i(wdata), .data_o(rd4), .mti_o(mti4), .msi_o(msi4)
    );

    typedef struct {
        string       name;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
        logic        exp_msi;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus access: driven mid-cycle, completes on the next rising edge;
    // returns 1 time unit after that edge so registered outputs can be sampled.
    task automatic bus(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        enable = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        enable = 1'b0; we = 4'h0;
        $display("bus we=%b addr=%h data=%h -> rd1=%h rd4=%h mti=%b msi=%b",
                 w, a, d, rd1, rd4, mti1, msi1);
    endtask

    initial begin
        vecs[0]  = '{"cmp_lo_byte_wr", 4'b0010, B + 32'h008, 32'h0000_AB00, 1'b0, 32'h0,          1'b0};
        vecs[1]  = '{"cmp_lo_byte_rd", 4'b0000, B + 32'h008, 32'h0,         1'b1, 32'hFFFF_ABFF, 1'b0};
        vecs[2]  = '{"cmp_hi_rd",      4'b0000, B + 32'h00C, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{"msip_set",       4'b0001, B,           32'h1,         1'b0, 32'h0,         1'b1};
        vecs[4]  = '{"msip_rd1",       4'b0000, B,           32'h0,         1'b1, 32'h1,         1'b1};
        vecs[5]  = '{"msip_upper_wr",  4'b1110, B,           32'h0,         1'b0, 32'h0,         1'b1};
        vecs[6]  = '{"msip_rd_keep",   4'b0000, B,           32'h0,         1'b1, 32'h1,         1'b1};
        vecs[7]  = '{"msip_clr",       4'b0001, B,           32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{"msip_rd0",       4'b0000, B,           32'h0,         1'b1, 32'h0,         1'b0};
        vecs[9]  = '{"off20_wr",       4'b1111, B + 32'h020, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{"off20_rd",       4'b0000, B + 32'h020, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[11] = '{"off04_rd",       4'b0000, B + 32'h004, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[12] = '{"out_msip_wr",    4'b0001, 32'h0900_0000, 32'h1,       1'b0, 32'h0,         1'b0};
        vecs[13] = '{"out_cmp_wr",     4'b1111, 32'h0900_0008, 32'h0,       1'b0, 32'h0,         1'b0};
        vecs[14] = '{"out_rd",         4'b0000, 32'h0900_0008, 32'h0,       1'b1, 32'h0,         1'b0};
        vecs[15] = '{"cmp_lo_intact",  4'b0000, B + 32'h008, 32'h0,         1'b1, 32'hFFFF_ABFF, 1'b0};

        // Reset state
        #22;
        chk("rst_data_o", rd1, 0);
        chk("rst_mti", mti1, 0);
        chk("rst_msi", msi1, 0);
        chk("rst_data_o_div4", rd4, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle count with TICK_DIV = 1
        repeat (10) @(posedge clk);
        #1;
        bus(4'b0000, B + 32'h010, 32'h0);
        checks++;
        if (rd1 < 32'd9 || rd1 > 32'd11) begin
            errors++;
            $display("FAIL idle_mtime_lo: got %0d expected 10 +/-1", rd1);
        end
        chk("idle_mti", mti1, 0);
        chk("idle_msi", msi1, 0);
        bus(4'b0000, B + 32'h00C, 32'h0);
        chk("idle_cmp_hi", rd1, 32'hFFFF_FFFF);

        // Register map, strobes, decode
        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].data);
            if (vecs[i].chk) chk(vecs[i].name, rd1, vecs[i].exp);
            chk({vecs[i].name, "_msi"}, msi1, vecs[i].exp_msi);
        end

        // Low-to-high carry with TICK_DIV = 4
        bus(4'b1111, B + 32'h010, 32'hFFFF_FFFF);
        bus(4'b1111, B + 32'h014, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        bus(4'b0000, B + 32'h010, 32'h0);
        chk("carry_lo_div4", rd4, 32'h0);
        bus(4'b0000, B + 32'h014, 32'h0);
        chk("carry_hi_div4", rd4, 32'h1);

        // mti rises one cycle after mtime reaches mtimecmp, drops after cmp raised
        bus(4'b1111, B + 32'h014, 32'h0);
        bus(4'b1111, B + 32'h010, 32'd5);
        bus(4'b1111, B + 32'h008, 32'd20);
        bus(4'b1111, B + 32'h00C, 32'h0);
        repeat (13) @(posedge clk);
        #1;
        chk("mti_before", mti1, 0);
        @(posedge clk);
        #1;
        chk("mti_rise", mti1, 1);
        bus(4'b1111, B + 32'h00C, 32'h1);
        chk("mti_hold", mti1, 1);
        @(posedge clk);
        #1;
        chk("mti_drop", mti1, 0);

        // Write in a tick cycle drops the increment; partial write keeps other bytes
        bus(4'b1111, B + 32'h010, 32'd100);
        bus(4'b0000, B + 32'h010, 32'h0);
        chk("tick_wr", rd1, 32'd100);
        chk("tick_wr_div4", rd4, 32'd100);
        bus(4'b0001, B + 32'h010, 32'h0000_00AA);
        bus(4'b0000, B + 32'h010, 32'h0);
        chk("byte_wr_mtime", rd1, 32'h0000_00AA);
        chk("byte_wr_mtime_div4", rd4, 32'h0000_00AA);

        // 64-bit wrap
        bus(4'b1111, B + 32'h014, 32'hFFFF_FFFF);
        bus(4'b1111, B + 32'h010, 32'hFFFF_FFFF);
        bus(4'b0000, B + 32'h010, 32'h0);
        chk("wrap_lo", rd1, 32'hFFFF_FFFF);
        bus(4'b0000, B + 32'h014, 32'h0);
        chk("wrap_hi", rd1, 32'h0);

        // Asynchronous reset mid-count
        bus(4'b0001, B, 32'h1);
        bus(4'b0000, B + 32'h010, 32'h0);
        chk("pre_rst_msi", msi1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_data_o", rd1, 0);
        chk("async_rst_data_o_div4", rd4, 0);
        chk("async_rst_msi", msi1, 0);
        chk("async_rst_mti", mti1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus(4'b0000, B + 32'h00C, 32'h0);
        chk("post_rst_cmp_hi", rd1, 32'hFFFF_FFFF);
        bus(4'b0000, B, 32'h0);
        chk("post_rst_msip", rd1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
